core_inst_sequencer: RTL and testbench
======================================

# core_inst_sequencer

Generates the 34-bit instruction word that drives the core (input SRAM, accumulation SRAM and corelet) through a full convolution pass. For each kernel index it:
- loads one weight tile into the PE array;
- streams an activation tile through it;
- drains the output FIFO into the accumulation SRAM.

It sits between the testbench/host `start` command and the core's `inst` port.

## Interface
- `row`, 8: PE array rows; weight words per tile.
- `col`, 8: PE array columns; drives the flush length.
- `addr_w`, 11: SRAM address width.
- `len_w`, 11: width of length/count configuration fields.
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high. Returns to IDLE and the idle instruction on the next edge.
- `start` in 1: one-cycle request. Sampled only in IDLE.
- `w_base` in addr_w: input-SRAM base of weight tile 0. Tile k starts at `w_base + k*row`.
- `x_base` in addr_w: input-SRAM base of activations.
- `p_base` in addr_w: accumulation-SRAM base for psums.
- `n_act` in len_w: activation vectors per pass.
- `n_kij` in len_w: kernel indices to iterate.
- `ofifo_valid` in 1: core's output FIFO has data.
- `inst` out 34: registered instruction word. Field layout:
  - [33] acc
  - [32] CEN_pmem
  - [31] WEN_pmem
  - [30:20] A_pmem
  - [19] CEN_xmem
  - [18] WEN_xmem
  - [17:7] A_xmem
  - [6] ofifo_rd
  - [5] ififo_wr
  - [4] ififo_rd
  - [3] l0_rd
  - [2] l0_wr
  - [1] execute
  - [0] load
- `busy` out 1: high outside IDLE.
- `done` out 1: one-cycle pulse when the last psum is written.

## Operation
- Idle instruction: CEN/WEN of both SRAMs = 1; all other bits 0. Same as reset value of `inst`.
- Reset values: `busy=0`, `done=0`.
- `config` (`w_base`, `x_base`, `p_base`, `n_act`, `n_kij`) is latched on accepted `start`. Later changes are ignored until the next start.
- Zero-length pass: if `n_act==0` or `n_kij==0`, the block emits no SRAM access and pulses `done` one cycle after `start`.
- State machine; `k` is the kernel counter, `i` the step counter.
  - IDLE → W_READ on `start`.
  - W_READ, `row` cycles: CEN_x=0, WEN_x=1, A_x=`w_base+k*row+i`. `l0_wr` is asserted one cycle after each read (SRAM read latency 1), so it trails by one cycle.
  - W_LOAD, `row` cycles: load=1, l0_rd=1. This state is entered after the last trailing `l0_wr` (one gap cycle).
  - W_FLUSH: `col` idle cycles.
  - X_READ, `n_act` cycles: A_x=`x_base+i`, read enabled, `l0_wr` trails by one cycle.
  - EXEC, `n_act` cycles: execute=1, l0_rd=1.
  - DRAIN: `row+col` idle cycles.
  - OUT: whenever `ofifo_valid`=1, assert ofifo_rd.
    - The cycle after each ofifo_rd: CEN_p=0, WEN_p=0, A_p=`p_base+k*n_act+j`, with `j` counting 0..n_act-1.
    - Leave OUT after the n_act-th pmem write.
  - Kernel loop: after OUT, if `k<n_kij-1`, increment `k` and go to W_READ; else pulse `done` and go to IDLE.
- acc bit is held 0. Accumulation is a separate pass.
- Address arithmetic is modulo 2^addr_w (wraps silently).
- `start` while busy is ignored.
- OUT waits indefinitely for `ofifo_valid`. Only reset aborts a pass.

## Timing
- First instruction (W_READ, A_x=`w_base`) appears on `inst` the cycle after `start` is sampled.
- All `inst` fields are registered; no combinational path from inputs to `inst`.
- Trailing `l0_wr` is exactly one cycle after its matching read. It is never dropped at a state boundary.
- pmem write lands exactly one cycle after its ofifo_rd. Back-to-back ofifo_rd is allowed, giving consecutive writes.
- `done` is asserted the cycle after the final pmem write. `busy` falls in the same cycle.
- Reset mid-pass: the next cycle shows the idle instruction and `busy=0`. Counters clear, and any pending trailing `l0_wr` or pmem write is discarded.

## Structure
- Shared package `core_pkg` holds:
  - instruction bit-position constants (ACC_B=33 … LOAD_B=0);
  - the idle-instruction constant;
  - the state enum.
- One natural sub-module: `inst_delay_slot`. It is a one-cycle register that carries trailing `l0_wr` and pending pmem write/address into the next instruction. Everything else lives in the top FSM.

## Test plan
- Basic pass: n_kij=1, n_act=4, w_base=0, x_base=16, p_base=0, `ofifo_valid` always 1.
  - A_x sequence 0..7 then 16..19.
  - 8 load cycles, 4 execute cycles.
  - pmem writes at 0..3.
  - `done` one cycle after the write at 3.
- Multi-kernel: n_kij=3, n_act=2, w_base=8 → weight reads at 8..15, 16..23, 24..31; psum writes at p_base+0..5.
- Stalled FIFO: `ofifo_valid` toggles 1,0,0,1 → ofifo_rd only on valid cycles; each pmem write exactly one cycle later; no duplicate addresses.
- Zero length: n_act=0 → `done` at cycle+1; CEN_x, CEN_p stay 1 throughout.
- Reset mid-EXEC → the next `inst` equals the idle word; `busy=0`; a following `start` replays from A_x=`w_base`.
- `start` asserted during busy and config changed mid-pass → no effect; addresses follow the latched config.

Source files
------------

// File: rtl/core_pkg.sv
// -----------------------------------------------------------------------------
// core_pkg
// Shared definitions for the core instruction sequencer:
//   - bit positions of the 34-bit core instruction word
//   - the idle instruction (both SRAMs disabled, every strobe low)
//   - the sequencer state encoding
//   - helpers that stamp an SRAM access into an instruction word
// -----------------------------------------------------------------------------
package core_pkg;

  localparam int INST_W  = 34;
  localparam int SRAM_AW = 11;  // address field width inside the instruction

  localparam int ACC_B      = 33;
  localparam int CEN_P_B    = 32;
  localparam int WEN_P_B    = 31;
  localparam int A_P_HI     = 30;
  localparam int A_P_LO     = 20;
  localparam int CEN_X_B    = 19;
  localparam int WEN_X_B    = 18;
  localparam int A_X_HI     = 17;
  localparam int A_X_LO     = 7;
  localparam int OFIFO_RD_B = 6;
  localparam int IFIFO_WR_B = 5;
  localparam int IFIFO_RD_B = 4;
  localparam int L0_RD_B    = 3;
  localparam int L0_WR_B    = 2;
  localparam int EXEC_B     = 1;
  localparam int LOAD_B     = 0;

  // CEN/WEN of both SRAMs high (bits 32, 31, 19, 18), everything else low.
  localparam logic [INST_W-1:0] IDLE_INST = 34'h1_800C_0000;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_W_READ  = 4'd1,
    S_W_GAP   = 4'd2,  // carries the last trailing l0_wr before loading
    S_W_LOAD  = 4'd3,
    S_W_FLUSH = 4'd4,
    S_X_READ  = 4'd5,
    S_EXEC    = 4'd6,
    S_DRAIN   = 4'd7,
    S_OUT     = 4'd8
  } state_e;

  // Stamp an input-SRAM read at addr into an instruction word.
  function automatic logic [INST_W-1:0] with_xmem_read(input logic [INST_W-1:0] inst,
                                                       input logic [SRAM_AW-1:0] addr);
    logic [INST_W-1:0] r;
    r                = inst;
    r[CEN_X_B]       = 1'b0;
    r[WEN_X_B]       = 1'b1;
    r[A_X_HI:A_X_LO] = addr;
    return r;
  endfunction

  // Stamp an accumulation-SRAM write at addr into an instruction word.
  function automatic logic [INST_W-1:0] with_pmem_write(input logic [INST_W-1:0] inst,
                                                        input logic [SRAM_AW-1:0] addr);
    logic [INST_W-1:0] r;
    r                = inst;
    r[CEN_P_B]       = 1'b0;
    r[WEN_P_B]       = 1'b0;
    r[A_P_HI:A_P_LO] = addr;
    return r;
  endfunction

endpackage

// File: rtl/core_inst_sequencer_slot.sv
// -----------------------------------------------------------------------------
// inst_delay_slot
// One-cycle carry register for actions that must land exactly one cycle after
// the instruction that caused them: the L0 write that follows an SRAM read and
// the psum write that follows an output-FIFO read.
// Ports:
//   clk_i, reset_i         clock, synchronous active-high reset (drops pending)
//   l0_wr_i                the instruction being issued reads the input SRAM
//   pmem_wr_i/pmem_addr_i  the instruction being issued pops the output FIFO
//   l0_wr_o                l0_wr owed to the next instruction
//   pmem_wr_o/pmem_addr_o  psum write owed to the next instruction
// -----------------------------------------------------------------------------
module inst_delay_slot
  import core_pkg::*;
#(
  parameter int ADDR_W = SRAM_AW
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              l0_wr_i,
  input  logic              pmem_wr_i,
  input  logic [ADDR_W-1:0] pmem_addr_i,
  output logic              l0_wr_o,
  output logic              pmem_wr_o,
  output logic [ADDR_W-1:0] pmem_addr_o
);

  logic              l0_wr_q;
  logic              pmem_wr_q;
  logic [ADDR_W-1:0] pmem_addr_q;

  // Capture the deferred actions alongside the instruction register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      l0_wr_q     <= 1'b0;
      pmem_wr_q   <= 1'b0;
      pmem_addr_q <= '0;
    end else begin
      l0_wr_q     <= l0_wr_i;
      pmem_wr_q   <= pmem_wr_i;
      pmem_addr_q <= pmem_addr_i;
    end
  end

  assign l0_wr_o     = l0_wr_q;
  assign pmem_wr_o   = pmem_wr_q;
  assign pmem_addr_o = pmem_addr_q;

endmodule

// File: rtl/core_inst_sequencer.sv
// -----------------------------------------------------------------------------
// core_inst_sequencer
// Emits the registered 34-bit core instruction for a convolution pass. Per
// kernel index: read ROW weight words, load them into the PE array, flush,
// read and execute n_act activation vectors, drain, then move n_act psums
// from the output FIFO into the accumulation SRAM.
// Ports:
//   clk_i, reset_i           clock, synchronous active-high reset
//   start_i                  one-cycle pass request, honoured only when idle
//   w_base_i/x_base_i/p_base_i  weight, activation, psum base addresses
//   n_act_i, n_kij_i         activation vectors per pass, kernel indices
//   ofifo_valid_i            output FIFO holds data
//   inst_o                   registered instruction word
//   busy_o                   pass in progress
//   done_o                   one-cycle pulse after the final psum write
// ADDR_W must equal the instruction address field width (11).
// -----------------------------------------------------------------------------
module core_inst_sequencer
  import core_pkg::*;
#(
  parameter int ROW    = 8,
  parameter int COL    = 8,
  parameter int ADDR_W = 11,
  parameter int LEN_W  = 11
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] w_base_i,
  input  logic [ADDR_W-1:0] x_base_i,
  input  logic [ADDR_W-1:0] p_base_i,
  input  logic [LEN_W-1:0]  n_act_i,
  input  logic [LEN_W-1:0]  n_kij_i,
  input  logic              ofifo_valid_i,
  output logic [INST_W-1:0] inst_o,
  output logic              busy_o,
  output logic              done_o
);

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  k_q, k_d;    // kernel index
  logic [LEN_W-1:0]  i_q, i_d;    // step within the current state
  logic [LEN_W-1:0]  rd_q, rd_d;  // output FIFO pops issued this kernel
  logic [ADDR_W-1:0] w_base_q, w_base_d, x_base_q, x_base_d, p_base_q, p_base_d;
  logic [LEN_W-1:0]  n_act_q, n_act_d, n_kij_q, n_kij_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic              busy_q, busy_d, done_q, done_d;

  // Content of the instruction issued at the next edge.
  logic              xrd_d, load_d, exec_d, ofifo_rd_d;
  logic [ADDR_W-1:0] xaddr_d, paddr_d;

  logic              slot_l0_wr, slot_pmem_wr;
  logic [ADDR_W-1:0] slot_pmem_addr;

  // State sequencing, counters, config latch and FIFO pop decision.
  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    i_d        = i_q;
    rd_d       = rd_q;
    w_base_d   = w_base_q;
    x_base_d   = x_base_q;
    p_base_d   = p_base_q;
    n_act_d    = n_act_q;
    n_kij_d    = n_kij_q;
    done_d     = 1'b0;
    ofifo_rd_d = 1'b0;
    paddr_d    = p_base_q + ADDR_W'(k_q) * ADDR_W'(n_act_q) + ADDR_W'(rd_q);
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          w_base_d = w_base_i;
          x_base_d = x_base_i;
          p_base_d = p_base_i;
          n_act_d  = n_act_i;
          n_kij_d  = n_kij_i;
          k_d      = '0;
          i_d      = '0;
          rd_d     = '0;
          if ((n_act_i == '0) || (n_kij_i == '0)) begin
            done_d = 1'b1;  // nothing to do: acknowledge and stay idle
          end else begin
            state_d = S_W_READ;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_W_READ: begin
        if (i_q == LEN_W'(ROW - 1)) begin
          state_d = S_W_GAP;
          i_d     = '0;
        end else begin
          i_d = i_q + LEN_W'(1);
        end
      end
      S_W_GAP: begin
        state_d = S_W_LOAD;
        i_d     = '0;
      end
      S_W_LOAD: begin
        if (i_q == LEN_W'(ROW - 1)) begin
          state_d = S_W_FLUSH;
          i_d     = '0;
        end else begin
          i_d = i_q + LEN_W'(1);
        end
      end
      S_W_FLUSH: begin
        if (i_q == LEN_W'(COL - 1)) begin
          state_d = S_X_READ;
          i_d     = '0;
        end else begin
          i_d = i_q + LEN_W'(1);
        end
      end
      S_X_READ: begin
        // The last read's trailing l0_wr rides on the first EXEC instruction.
        if (i_q == n_act_q - LEN_W'(1)) begin
          state_d = S_EXEC;
          i_d     = '0;
        end else begin
          i_d = i_q + LEN_W'(1);
        end
      end
      S_EXEC: begin
        if (i_q == n_act_q - LEN_W'(1)) begin
          state_d = S_DRAIN;
          i_d     = '0;
        end else begin
          i_d = i_q + LEN_W'(1);
        end
      end
      S_DRAIN: begin
        if (i_q == LEN_W'(ROW + COL - 1)) begin
          state_d = S_OUT;
          i_d     = '0;
          rd_d    = '0;
        end else begin
          i_d = i_q + LEN_W'(1);
        end
      end
      S_OUT: begin
        // Stay until the write owed by the last pop has been issued.
        if ((rd_q == n_act_q) && !slot_pmem_wr) begin
          if (k_q == n_kij_q - LEN_W'(1)) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = S_W_READ;
            k_d     = k_q + LEN_W'(1);
            i_d     = '0;
          end
        end else if (ofifo_valid_i && (rd_q != n_act_q)) begin
          ofifo_rd_d = 1'b1;
          rd_d       = rd_q + LEN_W'(1);
        end else begin
          ofifo_rd_d = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Decode the next instruction's own actions from the next state.
  always_comb begin
    xrd_d   = 1'b0;
    load_d  = 1'b0;
    exec_d  = 1'b0;
    xaddr_d = w_base_d + ADDR_W'(k_d) * ADDR_W'(ROW) + ADDR_W'(i_d);
    case (state_d)
      S_W_READ: xrd_d = 1'b1;
      S_X_READ: begin
        xrd_d   = 1'b1;
        xaddr_d = x_base_d + ADDR_W'(i_d);
      end
      S_W_LOAD: load_d = 1'b1;
      S_EXEC:   exec_d = 1'b1;
      default:  xrd_d = 1'b0;
    endcase
  end

  // Assemble the next instruction word, merging the deferred slot actions.
  always_comb begin
    logic [INST_W-1:0] base;
    base             = IDLE_INST;
    base[LOAD_B]     = load_d;
    base[EXEC_B]     = exec_d;
    base[L0_RD_B]    = load_d | exec_d;
    base[L0_WR_B]    = slot_l0_wr;
    base[OFIFO_RD_B] = ofifo_rd_d;
    if (xrd_d) begin
      base = with_xmem_read(base, xaddr_d);
    end else begin
      base[CEN_X_B] = 1'b1;
    end
    if (slot_pmem_wr) begin
      inst_d = with_pmem_write(base, slot_pmem_addr);
    end else begin
      inst_d = base;
    end
    busy_d = (state_d != S_IDLE);
  end

  inst_delay_slot #(.ADDR_W(ADDR_W)) u_slot (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .l0_wr_i     (xrd_d),
    .pmem_wr_i   (ofifo_rd_d),
    .pmem_addr_i (paddr_d),
    .l0_wr_o     (slot_l0_wr),
    .pmem_wr_o   (slot_pmem_wr),
    .pmem_addr_o (slot_pmem_addr)
  );

  // State, counters, latched config and the registered outputs.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= S_IDLE;
      k_q      <= '0;
      i_q      <= '0;
      rd_q     <= '0;
      w_base_q <= '0;
      x_base_q <= '0;
      p_base_q <= '0;
      n_act_q  <= '0;
      n_kij_q  <= '0;
      inst_q   <= IDLE_INST;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      i_q      <= i_d;
      rd_q     <= rd_d;
      w_base_q <= w_base_d;
      x_base_q <= x_base_d;
      p_base_q <= p_base_d;
      n_act_q  <= n_act_d;
      n_kij_q  <= n_kij_d;
      inst_q   <= inst_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign inst_o = inst_q;
  assign busy_o = busy_q;
  assign done_o = done_q;

endmodule

// File: tb/tb_core_inst_sequencer.sv
module tb_core_inst_sequencer;

  localparam int ROW = 8;
  localparam int COL = 8;
  localparam logic [33:0] IDLE_WORD = 34'h1_800C_0000;

  logic        clk = 1'b0;
  logic        reset_i, start_i, ofifo_valid_i;
  logic [10:0] w_base_i, x_base_i, p_base_i, n_act_i, n_kij_i;
  logic [33:0] inst_o;
  logic        busy_o, done_o;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  core_inst_sequencer #(.ROW(ROW), .COL(COL), .ADDR_W(11), .LEN_W(11)) dut (
    .clk_i         (clk),
    .reset_i       (reset_i),
    .start_i       (start_i),
    .w_base_i      (w_base_i),
    .x_base_i      (x_base_i),
    .p_base_i      (p_base_i),
    .n_act_i       (n_act_i),
    .n_kij_i       (n_kij_i),
    .ofifo_valid_i (ofifo_valid_i),
    .inst_o        (inst_o),
    .busy_o        (busy_o),
    .done_o        (done_o)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One pass. Expected read/write address lists come straight from the
  // address rules; timing relations are checked event to event.
  // vmode: 0 valid always high, 1 pattern 1,0,0,1, 2 random.
  task automatic run_pass(input logic [10:0] wb, input logic [10:0] xb, input logic [10:0] pb,
                          input logic [10:0] na, input logic [10:0] nk, input int vmode,
                          input int abort_exec, input bit poke);
    logic [10:0] exp_x[$];
    logic [10:0] exp_p[$];
    logic [33:0] w;
    logic [3:0]  pat = 4'b1001;
    int cyc, ridx, pos, kk, nai, nki;
    int n_load, n_exec, n_l0wr, last_xrd, last_load, last_exec, last_pw;
    bit prev_xrd, prev_ord, prev_load, prev_exec, cur_valid, fin;
    nai = int'(na);
    nki = int'(nk);
    for (int k = 0; k < nki && nai > 0; k++) begin
      for (int r = 0; r < ROW; r++) exp_x.push_back(11'(int'(wb) + k * ROW + r));
      for (int a = 0; a < nai; a++) exp_x.push_back(11'(int'(xb) + a));
      for (int j = 0; j < nai; j++) exp_p.push_back(11'(int'(pb) + k * nai + j));
    end
    w_base_i = wb; x_base_i = xb; p_base_i = pb; n_act_i = na; n_kij_i = nk;
    start_i = 1'b1; cur_valid = 1'b0; ofifo_valid_i = 1'b0;
    cyc = 0; ridx = 0; fin = 1'b0;
    n_load = 0; n_exec = 0; n_l0wr = 0;
    last_xrd = 0; last_load = 0; last_exec = 0; last_pw = 0;
    prev_xrd = 1'b0; prev_ord = 1'b0; prev_load = 1'b0; prev_exec = 1'b0;
    while (!fin && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      w = inst_o;
      if (cyc == 1 && nai > 0 && nki > 0) begin
        check_eq("first_xrd_en", w[19], 1'b0);
        check_eq("first_xaddr", w[17:7], wb);
      end
      check_eq("acc_ififo_low", {w[33], w[5], w[4]}, 3'b000);
      check_eq("l0_wr_trail", w[2], prev_xrd);
      check_eq("pmem_after_rd", !w[32], prev_ord);
      if (w[6]) begin
        check_eq("rd_needs_valid", cur_valid, 1'b1);
        check_eq("drain_len", (cyc - last_exec) > (ROW + COL), 1'b1);
      end
      if (!w[19]) begin
        check_eq("xmem_wen", w[18], 1'b1);
        check_eq("xrd_expected", exp_x.size() > 0, 1'b1);
        pos = ridx % (ROW + nai);
        kk  = ridx / (ROW + nai);
        if (pos == 0 && kk > 0) check_eq("kernel_restart", cyc, last_pw + 1);
        if (pos == ROW) check_eq("x_after_flush", cyc, last_load + COL + 1);
        if (exp_x.size() > 0) check_eq("xaddr", w[17:7], exp_x.pop_front());
        ridx++;
        last_xrd = cyc;
      end
      if (w[0]) begin
        n_load++;
        if (!prev_load) check_eq("load_start", cyc, last_xrd + 2);
        check_eq("load_l0rd", w[3], 1'b1);
        last_load = cyc;
      end
      if (w[1]) begin
        n_exec++;
        if (!prev_exec) check_eq("exec_start", cyc, last_xrd + 1);
        check_eq("exec_l0rd", w[3], 1'b1);
        last_exec = cyc;
      end
      if (w[2]) n_l0wr++;
      if (!w[32]) begin
        check_eq("pmem_wen", w[31], 1'b0);
        check_eq("pmem_expected", exp_p.size() > 0, 1'b1);
        if (exp_p.size() > 0) check_eq("paddr", w[30:20], exp_p.pop_front());
        last_pw = cyc;
      end
      if (abort_exec > 0 && w[1] && n_exec == abort_exec) begin
        reset_i = 1'b1;
        start_i = 1'b0;
        @(negedge clk);
        check_eq("abort_inst", inst_o, IDLE_WORD);
        check_eq("abort_busy", busy_o, 1'b0);
        check_eq("abort_done", done_o, 1'b0);
        reset_i = 1'b0;
        return;
      end
      if (done_o) begin
        fin = 1'b1;
        check_eq("done_time", cyc, last_pw + 1);
        check_eq("done_busy", busy_o, 1'b0);
        check_eq("x_left", exp_x.size(), 0);
        check_eq("p_left", exp_p.size(), 0);
        check_eq("n_load", n_load, nki * ROW * (nai > 0 ? 1 : 0));
        check_eq("n_exec", n_exec, nki * nai);
        check_eq("n_l0wr", n_l0wr, (nai > 0) ? nki * (ROW + nai) : 0);
      end else begin
        check_eq("busy_in_pass", busy_o, 1'b1);
      end
      prev_xrd = !w[19]; prev_ord = w[6]; prev_load = w[0]; prev_exec = w[1];
      cur_valid = (vmode == 0) ? 1'b1 : (vmode == 1) ? pat[cyc % 4] : 1'($urandom_range(0, 1));
      ofifo_valid_i = cur_valid;
      if (poke && !fin) begin
        start_i  = 1'($urandom_range(0, 1));
        w_base_i = 11'($urandom); x_base_i = 11'($urandom); p_base_i = 11'($urandom);
        n_act_i  = 11'($urandom); n_kij_i  = 11'($urandom);
      end else begin
        start_i = 1'b0;
      end
    end
    if (!fin) begin
      check_eq("pass_timeout", fin, 1'b1);
    end else begin
      @(negedge clk);
      check_eq("post_done_inst", inst_o, IDLE_WORD);
      check_eq("post_done_pulse", done_o, 1'b0);
    end
  endtask

  initial begin
    reset_i = 1'b1; start_i = 1'b0; ofifo_valid_i = 1'b0;
    w_base_i = '0; x_base_i = '0; p_base_i = '0; n_act_i = '0; n_kij_i = '0;
    repeat (3) @(negedge clk);
    check_eq("reset_inst", inst_o, IDLE_WORD);
    check_eq("reset_busy", busy_o, 1'b0);
    check_eq("reset_done", done_o, 1'b0);
    reset_i = 1'b0;

    run_pass(11'd0, 11'd16, 11'd0, 11'd4, 11'd1, 0, 0, 1'b0);       // basic
    run_pass(11'd8, 11'd100, 11'd40, 11'd2, 11'd3, 0, 0, 1'b0);     // multi-kernel
    run_pass(11'd5, 11'd200, 11'd300, 11'd3, 11'd2, 1, 0, 1'b0);    // stalled FIFO
    run_pass(11'd10, 11'd20, 11'd30, 11'd0, 11'd2, 0, 0, 1'b0);     // zero n_act
    run_pass(11'd10, 11'd20, 11'd30, 11'd3, 11'd0, 0, 0, 1'b0);     // zero n_kij
    run_pass(11'd50, 11'd60, 11'd70, 11'd4, 11'd2, 0, 2, 1'b0);     // reset mid-EXEC
    run_pass(11'd50, 11'd60, 11'd70, 11'd4, 11'd2, 0, 0, 1'b0);     // replay
    run_pass(11'd33, 11'd44, 11'd55, 11'd3, 11'd2, 2, 0, 1'b1);     // busy start + config churn
    run_pass(11'd2044, 11'd2046, 11'd2045, 11'd5, 11'd2, 2, 0, 1'b0); // address wrap
    for (int p = 0; p < 6; p++) begin
      run_pass(11'($urandom), 11'($urandom), 11'($urandom), 11'($urandom_range(1, 6)),
               11'($urandom_range(1, 3)), 2, 0, 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
